// File: rtl/ex_stage_if.sv
// Operand bundle from the decode/execute register plus the execute-stage results.
// master = pipeline side driving operands; slave = ex_stage.
interface ex_stage_if #(
   parameter int XLEN = 32
);
   logic [1:0]      ALUOpE;
   logic [2:0]      Funct3E;
   logic [6:0]      Funct7E;
   logic            ALUSrcE;
   logic            JumpE;
   logic            BranchE;
   logic [XLEN-1:0] RD1E;
   logic [XLEN-1:0] RD2E;
   logic [XLEN-1:0] ImmExtE;
   logic [XLEN-1:0] PCE;
   logic [1:0]      ForwardAE;
   logic [1:0]      ForwardBE;
   logic [XLEN-1:0] ALUResultM;
   logic [XLEN-1:0] ResultW;
   logic [XLEN-1:0] ALUResultE;
   logic [XLEN-1:0] WriteDataE;
   logic [XLEN-1:0] PCTargetE;
   logic            PCSrcE;
   logic            StallMD;

   modport master (
      output ALUOpE, Funct3E, Funct7E, ALUSrcE, JumpE, BranchE,
             RD1E, RD2E, ImmExtE, PCE, ForwardAE, ForwardBE, ALUResultM, ResultW,
      input  ALUResultE, WriteDataE, PCTargetE, PCSrcE, StallMD
   );

   modport slave (
      input  ALUOpE, Funct3E, Funct7E, ALUSrcE, JumpE, BranchE,
             RD1E, RD2E, ImmExtE, PCE, ForwardAE, ForwardBE, ALUResultM, ResultW,
      output ALUResultE, WriteDataE, PCTargetE, PCSrcE, StallMD
   );
endinterface

// File: rtl/ex_stage.sv
// RV32 execute stage: forwarding, ALU, branch resolution, optional RV32M unit.
// Define EX_MULDIV_EN to build the multiplier and the iterative divider.
module ex_stage #(
   parameter int XLEN = 32
) (
   input logic       clk,
   input logic       rst,
   ex_stage_if.slave bus
);
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] write_data;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;
   logic [XLEN-1:0] base_result;
   logic [XLEN-1:0] op_result;
   logic [4:0]      shamt;
   logic            lt_s;
   logic            lt_u;
   logic            eq;
   logic            cond;

   // 2'b11 falls back to the register value, same as 2'b00
   always_comb begin
      case (bus.ForwardAE)
         2'b01:   src_a = bus.ResultW;
         2'b10:   src_a = bus.ALUResultM;
         default: src_a = bus.RD1E;
      endcase
      case (bus.ForwardBE)
         2'b01:   write_data = bus.ResultW;
         2'b10:   write_data = bus.ALUResultM;
         default: write_data = bus.RD2E;
      endcase
   end

   assign src_b          = bus.ALUSrcE ? bus.ImmExtE : write_data;
   assign bus.WriteDataE = write_data;
   assign bus.PCTargetE  = bus.PCE + bus.ImmExtE;
   assign sum            = src_a + src_b;
   assign diff           = src_a - src_b;
   assign shamt          = src_b[4:0];
   assign lt_s           = $signed(src_a) < $signed(src_b);
   assign lt_u           = src_a < src_b;
   assign eq             = src_a == src_b;

   always_comb begin
      base_result = sum;
      case (bus.Funct3E)
         3'b000: base_result = (bus.Funct7E[5] && !bus.ALUSrcE) ? diff : sum;
         3'b001: base_result = src_a << shamt;
         3'b010: base_result = {{(XLEN-1){1'b0}}, lt_s};
         3'b011: base_result = {{(XLEN-1){1'b0}}, lt_u};
         3'b100: base_result = src_a ^ src_b;
         3'b101: base_result = bus.Funct7E[5] ? ($signed(src_a) >>> shamt) : (src_a >> shamt);
         3'b110: base_result = src_a | src_b;
         default: base_result = src_a & src_b;
      endcase
   end

   always_comb begin
      case (bus.ALUOpE)
         2'b01:   op_result = diff;
         2'b10:   op_result = base_result;
         default: op_result = sum;
      endcase
   end

   always_comb begin
      case (bus.Funct3E)
         3'b000:  cond = eq;
         3'b001:  cond = !eq;
         3'b100:  cond = lt_s;
         3'b101:  cond = !lt_s;
         3'b110:  cond = lt_u;
         3'b111:  cond = !lt_u;
         default: cond = 1'b0;
      endcase
   end

   // A redirect must not fire while the divider holds the pipeline
   assign bus.PCSrcE = (bus.JumpE | (bus.BranchE & cond)) & ~bus.StallMD;

`ifdef EX_MULDIV_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   logic                   is_m;
   logic                   mul_op;
   logic                   div_op;
   logic                   a_sgn_ext;
   logic                   b_sgn_ext;
   logic signed [2*XLEN-1:0] mul_a;
   logic signed [2*XLEN-1:0] mul_b;
   logic signed [2*XLEN-1:0] product;
   logic [XLEN-1:0]        mul_result;

   assign is_m      = (bus.ALUOpE == 2'b10) && (bus.Funct7E == 7'b0000001);
   assign mul_op    = is_m & ~bus.Funct3E[2];
   assign div_op    = is_m & bus.Funct3E[2];
   // mulhu treats rs1 as unsigned; only mulh treats rs2 as signed
   assign a_sgn_ext = (bus.Funct3E[1:0] != 2'b11) & src_a[XLEN-1];
   assign b_sgn_ext = (bus.Funct3E[1:0] == 2'b01) & src_b[XLEN-1];
   assign mul_a     = {{XLEN{a_sgn_ext}}, src_a};
   assign mul_b     = {{XLEN{b_sgn_ext}}, src_b};
   assign product   = mul_a * mul_b;
   assign mul_result = (bus.Funct3E[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

   div_state_t      state_reg, state_next;
   logic [4:0]      count_reg;
   logic [XLEN-1:0] divisor_reg;
   logic [XLEN-1:0] quo_reg;
   logic [XLEN-1:0] rem_reg;
   logic            rem_sel_reg;
   logic            neg_q_reg;
   logic            neg_r_reg;
   logic            div_signed;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN:0]   rem_shift;
   logic [XLEN:0]   rem_trial;
   logic            step_ok;
   logic [XLEN-1:0] div_result;
   logic            stall;

   assign div_signed = ~bus.Funct3E[0];
   assign a_mag      = (div_signed && src_a[XLEN-1]) ? (~src_a + 1'b1) : src_a;
   assign b_mag      = (div_signed && src_b[XLEN-1]) ? (~src_b + 1'b1) : src_b;

   // Restoring step: the dividend shifts out of quo_reg while quotient bits shift in
   assign rem_shift = {rem_reg, quo_reg[XLEN-1]};
   assign rem_trial = rem_shift - {1'b0, divisor_reg};
   assign step_ok   = ~rem_trial[XLEN];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         divisor_reg <= '0;
         quo_reg     <= '0;
         rem_reg     <= '0;
         rem_sel_reg <= 1'b0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: if (div_op) begin
               count_reg   <= '0;
               divisor_reg <= b_mag;
               quo_reg     <= a_mag;
               rem_reg     <= '0;
               rem_sel_reg <= bus.Funct3E[1];
               // Divide-by-zero keeps the all-ones quotient unnegated
               neg_q_reg   <= div_signed & (src_a[XLEN-1] ^ src_b[XLEN-1]) & (src_b != '0);
               neg_r_reg   <= div_signed & src_a[XLEN-1];
            end
            BUSY: begin
               rem_reg   <= step_ok ? rem_trial[XLEN-1:0] : rem_shift[XLEN-1:0];
               quo_reg   <= {quo_reg[XLEN-2:0], step_ok};
               count_reg <= count_reg + 5'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      stall      = 1'b0;
      case (state_reg)
         IDLE: if (div_op) begin
            state_next = BUSY;
            stall      = 1'b1;
         end
         BUSY: begin
            stall = 1'b1;
            if (count_reg == 5'd31) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign div_result = rem_sel_reg ? (neg_r_reg ? (~rem_reg + 1'b1) : rem_reg)
                                   : (neg_q_reg ? (~quo_reg + 1'b1) : quo_reg);

   assign bus.StallMD    = stall;
   assign bus.ALUResultE = (state_reg == DONE) ? div_result : (mul_op ? mul_result : op_result);
`else
   logic unused_sigs;
   assign unused_sigs    = ^{clk, rst, bus.Funct7E[6], bus.Funct7E[4:0]};
   assign bus.StallMD    = 1'b0;
   assign bus.ALUResultE = op_result;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_ex_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_stage_if bus();
   ex_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef EX_MULDIV_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif

   typedef struct {
      int          id;
      logic [31:0] res;
      logic [31:0] wd;
      logic [31:0] tgt;
      logic        pcsrc;
      bit          chk_wd;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   txn_id = 0;

   task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s txn=%0d got=%h want=%h", name, id, got, want);
      end
   endtask

   function automatic logic [31:0] fwd_m(input logic [1:0] sel, input logic [31:0] r, input logic [31:0] m,
                                         input logic [31:0] w);
      if (sel == 2'b01) return w;
      if (sel == 2'b10) return m;
      return r;
   endfunction

   function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                           input logic isrc, input logic [31:0] a, input logic [31:0] b);
      int          sa;
      int          sb;
      longint      p;
      logic [63:0] pu;
      sa = a;
      sb = b;
      if (op == 2'b01) return a - b;
      if (op != 2'b10) return a + b;
      if (M_EN && f7 == 7'd1) begin
         case (f3)
            3'd0: return a * b;
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'(b); return p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
               if (b == 0) return 32'hFFFF_FFFF;
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
               return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
               if (b == 0) return a;
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
               return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
         endcase
      end
      case (f3)
         3'd0: return (f7[5] && !isrc) ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return (sa < sb) ? 1 : 0;
         3'd3: return (a < b) ? 1 : 0;
         3'd4: return a ^ b;
         3'd5: return f7[5] ? sa >>> b[4:0] : a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic bit br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return sa < sb;
         3'd5: return sa >= sb;
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] rv();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return $urandom_range(0, 16);
         default: return $urandom;
      endcase
   endfunction

   // Drive one instruction, queue its expectation and hold it for as long as StallMD asks
   task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic isrc,
                        input logic jmp, input logic br, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [31:0] m, input logic [31:0] w);
      exp_t        e;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] b;
      bit          is_div;
      int          stall_cnt;
      is_div = M_EN && op == 2'b10 && f7 == 7'd1 && f3[2];
      if (is_div) br = 1'b0;
      bus.ALUOpE = op;     bus.Funct3E = f3;   bus.Funct7E = f7;
      bus.ALUSrcE = isrc;  bus.JumpE = jmp;    bus.BranchE = br;
      bus.RD1E = rd1;      bus.RD2E = rd2;     bus.ImmExtE = imm;  bus.PCE = pc;
      bus.ForwardAE = fa;  bus.ForwardBE = fb; bus.ALUResultM = m; bus.ResultW = w;
      a  = fwd_m(fa, rd1, m, w);
      wd = fwd_m(fb, rd2, m, w);
      b  = isrc ? imm : wd;
      e.id     = txn_id;
      txn_id++;
      e.res    = alu_ref(op, f3, f7, isrc, a, b);
      e.wd     = wd;
      e.tgt    = pc + imm;
      e.pcsrc  = jmp | (br & br_ref(f3, a, b));
      e.chk_wd = !is_div;
      sb_q.push_back(e);
      stall_cnt = 0;
      forever begin
         @(negedge clk);
         if (!bus.StallMD) break;
         stall_cnt++;
         if (stall_cnt == 1) chk("pcsrc_in_stall", e.id, {31'd0, bus.PCSrcE}, 32'd0);
         if (stall_cnt > 40) begin
            bad++;
            $display("FAIL stall_timeout txn=%0d got=%0d cycles want=33", e.id, stall_cnt);
            sb_q.delete();
            break;
         end
         @(posedge clk);
         #1;
         // Operands were latched in cycle 0; later forwarding values must be ignored
         bus.ALUResultM = $urandom;
         bus.ResultW    = $urandom;
      end
      chk("stall_len", e.id, stall_cnt, is_div ? 33 : 0);
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!bus.StallMD && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            $display("txn %0d res=%h tgt=%h pcsrc=%b", e.id, bus.ALUResultE, bus.PCTargetE, bus.PCSrcE);
            chk("alu_result", e.id, bus.ALUResultE, e.res);
            chk("pc_target", e.id, bus.PCTargetE, e.tgt);
            chk("pcsrc", e.id, {31'd0, bus.PCSrcE}, {31'd0, e.pcsrc});
            if (e.chk_wd) chk("write_data", e.id, bus.WriteDataE, e.wd);
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "simulation did not finish");
   end

   initial begin : stimulus
      logic [1:0] op;
      logic [6:0] f7;
      rst = 1'b1;
      bus.ALUOpE = 2'b00; bus.Funct3E = 3'd0; bus.Funct7E = 7'd0;
      bus.ALUSrcE = 1'b0; bus.JumpE = 1'b0;   bus.BranchE = 1'b0;
      bus.RD1E = 32'd0;   bus.RD2E = 32'd0;   bus.ImmExtE = 32'd0; bus.PCE = 32'd0;
      bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;
      bus.ALUResultM = 32'd0; bus.ResultW = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_stall", -1, {31'd0, bus.StallMD}, 32'd0);
      @(posedge clk);
      #1;

      issue(2'b10, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 2'b10, 2'b00, 32'd100, 32'd0);
      issue(2'b01, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h1234, 32'h20, 32'h100, 2'b00, 2'b00, 32'd0, 32'd0);
      issue(2'b01, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h1235, 32'h20, 32'h100, 2'b00, 2'b00, 32'd0, 32'd0);
      issue(2'b10, 3'd4, 7'd1, 1'b0, 1'b0, 1'b0, -32'sd7, 32'd2, 32'd0, 32'h40, 2'b00, 2'b00, 32'd0, 32'd0);
      issue(2'b10, 3'd6, 7'd1, 1'b0, 1'b0, 1'b0, -32'sd7, 32'd2, 32'd0, 32'h44, 2'b00, 2'b00, 32'd0, 32'd0);
      issue(2'b10, 3'd5, 7'd1, 1'b0, 1'b0, 1'b0, 32'd10, 32'd0, 32'd0, 32'h48, 2'b00, 2'b00, 32'd0, 32'd0);
      issue(2'b10, 3'd7, 7'd1, 1'b0, 1'b0, 1'b0, 32'd10, 32'd0, 32'd0, 32'h4c, 2'b00, 2'b00, 32'd0, 32'd0);
      issue(2'b10, 3'd4, 7'd1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8, 32'h50, 2'b00, 2'b00, 32'd0, 32'd0);
      issue(2'b10, 3'd1, 7'd1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
      issue(2'b10, 3'd3, 7'd1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);

      // Reset in cycle 10 of a divide; the add behind it must run with no stall
      bus.ALUOpE = 2'b10; bus.Funct3E = 3'd4; bus.Funct7E = 7'd1; bus.ALUSrcE = 1'b0;
      bus.JumpE = 1'b0;   bus.BranchE = 1'b0; bus.RD1E = 32'd1000; bus.RD2E = 32'd7;
      bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      issue(2'b10, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 32'd21, 32'd21, 32'd0, 32'h200, 2'b00, 2'b00, 32'd0, 32'd0);

      for (int i = 0; i < 250; i++) begin
         op = 2'($urandom_range(0, 2));
         case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'h01;
         endcase
         issue(op, 3'($urandom_range(0, 7)), f7, 1'($urandom), 1'($urandom), 1'($urandom), rv(), rv(), rv(),
               $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rv(), rv());
      end

      repeat (2) @(posedge clk);
      chk("queue_drained", -1, sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
